// File: rtl/vedic_mult_pkg.sv
// Shared widths, types and partial-product helper for the Vedic 2x2 multiplier.
// Used by vedic_multiplier_2x2 (optional checker enabled by VEDIC_MULT_SELFCHECK_EN).
package vedic_mult_pkg;

  localparam int VM_IN_W  = 2;
  localparam int VM_OUT_W = 4;

  typedef logic [VM_IN_W-1:0]  vm_in_t;
  typedef logic [VM_OUT_W-1:0] vm_out_t;

  // Vertical (p00, p11) and crosswise (p10, p01) partial products.
  typedef struct packed {
    logic p11;
    logic p10;
    logic p01;
    logic p00;
  } vm_pp_t;

  function automatic vm_pp_t vm_partials(input vm_in_t a, input vm_in_t b);
    vm_pp_t pp;
    pp.p00 = a[0] & b[0];
    pp.p01 = a[0] & b[1];
    pp.p10 = a[1] & b[0];
    pp.p11 = a[1] & b[1];
    return pp;
  endfunction

endpackage

// File: rtl/vedic_half_adder.sv
// One-bit half adder; two of these form the crosswise carry chain of the 2x2 core.
module vedic_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/vedic_multiplier_2x2.sv
// 2x2 unsigned Vedic (Urdhva-Tiryakbhyam) multiplier, 1 or 2 pipeline stages.
// Define VEDIC_MULT_SELFCHECK_EN to add the sticky err output and golden-product checker.
module vedic_multiplier_2x2
  import vedic_mult_pkg::*;
#(
  parameter int PIPE_STAGES = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  vm_in_t  A,
  input  vm_in_t  B,
  output vm_out_t M,
  output logic    out_valid
`ifdef VEDIC_MULT_SELFCHECK_EN
  ,
  output logic    err
`endif
);

  // Operands are masked with in_valid so unknowns on idle cycles never reach M.
  vm_in_t a_g;
  vm_in_t b_g;
  vm_pp_t pp_now;
  vm_pp_t pp_core;
  logic   v_core;

  assign a_g    = in_valid ? A : '0;
  assign b_g    = in_valid ? B : '0;
  assign pp_now = vm_partials(a_g, b_g);

`ifdef VEDIC_MULT_SELFCHECK_EN
  vm_out_t gold_now;
  vm_out_t gold_core;
  assign gold_now = {2'b00, a_g} * {2'b00, b_g};
`endif

  generate
    if (PIPE_STAGES == 1) begin : g_pipe1
      assign pp_core = pp_now;
      assign v_core  = in_valid;
`ifdef VEDIC_MULT_SELFCHECK_EN
      assign gold_core = gold_now;
`endif
    end else if (PIPE_STAGES == 2) begin : g_pipe2
      vm_pp_t pp_q;
      vm_pp_t pp_d;
      logic   v1_q;

      assign pp_d = in_valid ? pp_now : pp_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pp_q <= '0;
          v1_q <= 1'b0;
        end else begin
          pp_q <= pp_d;
          v1_q <= in_valid;
        end
      end

      assign pp_core = pp_q;
      assign v_core  = v1_q;

`ifdef VEDIC_MULT_SELFCHECK_EN
      vm_out_t gold1_q;
      vm_out_t gold1_d;

      assign gold1_d = in_valid ? gold_now : gold1_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gold1_q <= '0;
        end else begin
          gold1_q <= gold1_d;
        end
      end

      assign gold_core = gold1_q;
`endif
    end else begin : g_bad_pipe
      $error("vedic_multiplier_2x2: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

  // Half-adder network: M[1] from the crosswise pair, M[3:2] from p11 plus that carry.
  logic    m1_sum;
  logic    c1;
  logic    m2_sum;
  logic    m3_carry;
  vm_out_t prod;

  vedic_half_adder u_ha_cross (
    .a     (pp_core.p10),
    .b     (pp_core.p01),
    .sum   (m1_sum),
    .carry (c1)
  );

  vedic_half_adder u_ha_high (
    .a     (pp_core.p11),
    .b     (c1),
    .sum   (m2_sum),
    .carry (m3_carry)
  );

  assign prod = {m3_carry, m2_sum, m1_sum, pp_core.p00};

  vm_out_t m_q;
  vm_out_t m_d;
  logic    ov_q;

  assign m_d = v_core ? prod : m_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      ov_q <= v_core;
    end
  end

  assign M         = m_q;
  assign out_valid = ov_q;

`ifdef VEDIC_MULT_SELFCHECK_EN
  vm_out_t gold_q;
  vm_out_t gold_d;
  logic    err_q;
  logic    err_d;

  assign gold_d = v_core ? gold_core : gold_q;
  assign err_d  = err_q | (ov_q & (m_q != gold_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      gold_q <= gold_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_vedic_multiplier_2x2.sv
// Directed bench for vedic_multiplier_2x2; runs PIPE_STAGES=1 and 2 side by side on shared inputs.
// Covers the err checker when VEDIC_MULT_SELFCHECK_EN is defined.
module tb_vedic_multiplier_2x2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] A;
  logic [1:0] B;
  logic [3:0] m1;
  logic [3:0] m2;
  logic       ov1;
  logic       ov2;
`ifdef VEDIC_MULT_SELFCHECK_EN
  logic       err1;
  logic       err2;
`endif

  int total = 0;
  int bad   = 0;

  // Expected outputs: P1 follows inputs after one edge, P2 one edge later via pend_*.
  logic [3:0] e1_m, e2_m, pend_m;
  logic       e1_v, e2_v, pend_v;

  vedic_multiplier_2x2 #(.PIPE_STAGES(1)) u_p1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .M         (m1),
    .out_valid (ov1)
`ifdef VEDIC_MULT_SELFCHECK_EN
    ,
    .err       (err1)
`endif
  );

  vedic_multiplier_2x2 #(.PIPE_STAGES(2)) u_p2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .M         (m2),
    .out_valid (ov2)
`ifdef VEDIC_MULT_SELFCHECK_EN
    ,
    .err       (err2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " p1.M"},  m1,          e1_m);
    chk({tag, " p1.ov"}, {3'b0, ov1}, {3'b0, e1_v});
    chk({tag, " p2.M"},  m2,          e2_m);
    chk({tag, " p2.ov"}, {3'b0, ov2}, {3'b0, e2_v});
  endtask

  task automatic model_reset();
    e1_m = 4'h0; e1_v = 1'b0;
    e2_m = 4'h0; e2_v = 1'b0;
    pend_m = 4'h0; pend_v = 1'b0;
  endtask

  // Drive one operand pair with its hand-computed product, clock once, then check.
  task automatic cycle(input logic [1:0] a, input logic [1:0] b, input logic v,
                       input logic [3:0] p, input string tag);
    in_valid = v;
    A = v ? a : 2'bxx;
    B = v ? b : 2'bxx;
    @(posedge clk);
    #1;
    e2_v = pend_v;
    if (pend_v) e2_m = pend_m;
    pend_v = v;
    pend_m = p;
    e1_v = v;
    if (v) e1_m = p;
    chk_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 2'd3;
    B        = 2'd3;
    model_reset();
    #1;
    chk_all("reset_t0");
`ifdef VEDIC_MULT_SELFCHECK_EN
    chk("reset err1", {3'b0, err1}, 4'h0);
    chk("reset err2", {3'b0, err2}, 4'h0);
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_all("reset_hold");
    end
    rst_n = 1'b1;

    cycle(2'd2, 2'd0, 1'b1, 4'd0, "d_2x0");
    cycle(2'd3, 2'd3, 1'b1, 4'd9, "d_3x3");
    cycle(2'd1, 2'd3, 1'b1, 4'd3, "d_1x3");
    cycle(2'd3, 2'd1, 1'b1, 4'd3, "d_3x1");
    cycle(2'd2, 2'd2, 1'b1, 4'd4, "d_2x2");
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "d_idle0");
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "d_idle1");

    cycle(2'd3, 2'd2, 1'b1, 4'd6, "bub_3x2");
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "bub_gap");
    chk("bub p1 held", m1, 4'd6);
    cycle(2'd1, 2'd1, 1'b1, 4'd1, "bub_1x1");
    chk("bub p2 held", m2, 4'd6);
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "bub_tail0");
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "bub_tail1");
    chk("bub p2 final", m2, 4'd1);

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        cycle(2'(a), 2'(b), 1'b1, 4'(a * b), $sformatf("ex_%0dx%0d", a, b));
      end
    end
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "ex_drain0");
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "ex_drain1");
`ifdef VEDIC_MULT_SELFCHECK_EN
    chk("ex err1", {3'b0, err1}, 4'h0);
    chk("ex err2", {3'b0, err2}, 4'h0);
`endif

    // Asynchronous clear in the middle of a cycle, no clock edge involved.
    cycle(2'd3, 2'd3, 1'b1, 4'd9, "async_pre");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_clear");
    #1;
    rst_n = 1'b1;

    // Reset while 3x3 is still inside the two-stage pipe.
    cycle(2'd3, 2'd3, 1'b1, 4'd9, "flight_in");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("flight_rst");
    #1;
    rst_n = 1'b1;
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "flight_after0");
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "flight_after1");
    cycle(2'd0, 2'd0, 1'b0, 4'd0, "flight_after2");

`ifdef VEDIC_MULT_SELFCHECK_EN
    cycle(2'd1, 2'd1, 1'b1, 4'd1, "sc_pre0");
    cycle(2'd1, 2'd1, 1'b1, 4'd1, "sc_pre1");
    chk("sc err1 clean", {3'b0, err1}, 4'h0);
    force u_p1.m_q = 4'b0000;
    @(posedge clk);
    #1;
    release u_p1.m_q;
    @(posedge clk);
    #1;
    chk("sc err1 set", {3'b0, err1}, 4'h1);
    chk("sc err2 clean", {3'b0, err2}, 4'h0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sc err1 sticky", {3'b0, err1}, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("sc err1 cleared", {3'b0, err1}, 4'h0);
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
